// File: rtl/fir_result_buffer_if.sv
// ============================================================================
// Module      : fir_result_buffer_if
// Description : Sample-in, readback and status bundle for fir_result_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_result_buffer_if #(
    parameter int IN_W   = 93,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 11
);
    logic                     start;
    logic signed [IN_W-1:0]   data_in;
    logic                     valid_in;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [OUT_W-1:0]         rd_data;
    logic                     rd_valid;
    logic                     busy;
    logic                     done;
    logic [ADDR_W:0]          sample_count;
    logic                     sat_flag;

    modport master (
        output start, data_in, valid_in, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, done, sample_count, sat_flag
    );

    modport slave (
        input  start, data_in, valid_in, rd_en, rd_addr,
        output rd_data, rd_valid, busy, done, sample_count, sat_flag
    );
endinterface

`default_nettype wire

// File: rtl/fir_result_buffer.sv
// ============================================================================
// Module      : fir_result_buffer
// Description : Captures one frame of FIR results, rounds/scales/saturates
//               them into a DEPTH-entry RAM with synchronous readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_result_buffer #(
    parameter int IN_W      = 93,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 40,
    parameter int ADDR_W    = 11,
    parameter int FRAME_LEN = 2048
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fir_result_buffer_if.slave     bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic signed [IN_W:0] c_one   = (IN_W+1)'(1);
    localparam logic signed [IN_W:0] c_round = c_one <<< (SHIFT - 1);
    localparam logic signed [IN_W:0] c_max   = (c_one <<< (OUT_W - 1)) - c_one;
    localparam logic signed [IN_W:0] c_min   = -(c_one <<< (OUT_W - 1));
    localparam logic [ADDR_W:0]      c_frame = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [ADDR_W:0]      c_last  = (ADDR_W+1)'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 arm;

    logic                 stage_valid;
    logic [OUT_W-1:0]     stage_data;
    logic [ADDR_W:0]      accept_cnt;
    logic [ADDR_W:0]      sample_count;
    logic                 sat_flag;

    logic                 accept;
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rounded;
    logic signed [IN_W:0] scaled;
    logic [OUT_W-1:0]     sat_val;
    logic                 sat_hit;

    logic [OUT_W-1:0]     mem [DEPTH];
    logic [OUT_W-1:0]     rd_data;
    logic                 rd_valid;

    // ------------------------------------------------------------------
    // Frame control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_ARMED;
                    arm       = 1'b1;
                end
            end
            S_ARMED: begin
                if (stage_valid && (sample_count == c_last)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_nxt = S_ARMED;
                    arm       = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scale with round-half-up, then clamp. One guard bit keeps the
    // rounding add from wrapping at the top of the input range.
    // ------------------------------------------------------------------
    always_comb begin
        accept  = (state == S_ARMED) && bus.valid_in && (accept_cnt < c_frame);
        ext     = {bus.data_in[IN_W-1], bus.data_in};
        rounded = ext + c_round;
        scaled  = rounded >>> SHIFT;
        sat_hit = 1'b0;
        sat_val = scaled[OUT_W-1:0];
        if (scaled > c_max) begin
            sat_val = c_max[OUT_W-1:0];
            sat_hit = 1'b1;
        end else if (scaled < c_min) begin
            sat_val = c_min[OUT_W-1:0];
            sat_hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Accept stage and write bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid  <= 1'b0;
            stage_data   <= '0;
            accept_cnt   <= '0;
            sample_count <= '0;
            sat_flag     <= 1'b0;
        end else if (arm) begin
            stage_valid  <= 1'b0;
            accept_cnt   <= '0;
            sample_count <= '0;
            sat_flag     <= 1'b0;
        end else begin
            stage_valid <= accept;
            if (accept) begin
                stage_data <= sat_val;
                accept_cnt <= accept_cnt + 1'b1;
                if (sat_hit) begin
                    sat_flag <= 1'b1;
                end
            end
            if (stage_valid) begin
                sample_count <= sample_count + 1'b1;
            end
        end
    end

    // RAM contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (stage_valid) begin
            mem[sample_count[ADDR_W-1:0]] <= stage_data;
        end
    end

    // Read register samples the pre-write contents on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data <= mem[bus.rd_addr];
            end
        end
    end

    assign bus.rd_data      = rd_data;
    assign bus.rd_valid     = rd_valid;
    assign bus.busy         = (state == S_ARMED);
    assign bus.done         = (state == S_DONE);
    assign bus.sample_count = sample_count;
    assign bus.sat_flag     = sat_flag;

endmodule

`default_nettype wire

// File: tb/tb_fir_result_buffer.sv
// ============================================================================
// Module      : tb_fir_result_buffer
// Description : Directed self-checking bench for fir_result_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_result_buffer;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    fir_result_buffer_if #(.IN_W(93), .OUT_W(16), .ADDR_W(11)) bus ();

    fir_result_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [92:0] sh(input int v);
        logic signed [92:0] t;
        t = v;
        return t <<< 40;
    endfunction

    task automatic rd(input int a, input logic [15:0] exp, input string tag);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 11'(a);
        tick();
        bus.rd_en   = 1'b0;
        chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
        chk(tag, 64'(bus.rd_data), 64'(exp));
    endtask

    task automatic push(input logic signed [92:0] d);
        bus.data_in  = d;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
    endtask

    logic signed [92:0] half;
    logic signed [92:0] dv [8];
    logic [15:0]        ev [8];

    initial begin
        vectors      = 0;
        errors       = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        half         = 93'sd1;
        half         = half <<< 39;

        // Reset state
        tick();
        tick();
        chk("rst_rd_data",  64'(bus.rd_data), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_busy",     64'(bus.busy), 64'd0);
        chk("rst_done",     64'(bus.done), 64'd0);
        chk("rst_count",    64'(bus.sample_count), 64'd0);
        chk("rst_sat",      64'(bus.sat_flag), 64'd0);
        rst = 1'b1;
        tick();

        // Valids in IDLE are dropped
        for (int i = 0; i < 3; i++) push(sh(5));
        chk("idle_count", 64'(bus.sample_count), 64'd0);
        chk("idle_busy",  64'(bus.busy), 64'd0);

        // Full ramp; valid coincident with start is not accepted
        bus.start    = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = sh(99);
        tick();
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
        chk("arm_busy",  64'(bus.busy), 64'd1);
        chk("arm_count", 64'(bus.sample_count), 64'd0);
        for (int k = 0; k < 2048; k++) begin
            bus.start = (k == 1000);
            push(sh(k));
            bus.start = 1'b0;
            tick();
        end
        chk("ramp_done",  64'(bus.done), 64'd1);
        chk("ramp_busy",  64'(bus.busy), 64'd0);
        chk("ramp_count", 64'(bus.sample_count), 64'd2048);
        chk("ramp_sat",   64'(bus.sat_flag), 64'd0);
        rd(0,    16'd0,    "ramp_rd0");
        rd(1,    16'd1,    "ramp_rd1");
        rd(1000, 16'd1000, "ramp_rd1000");
        rd(2047, 16'd2047, "ramp_rd2047");
        tick();
        chk("rd_idle_valid", 64'(bus.rd_valid), 64'd0);
        chk("rd_hold_data",  64'(bus.rd_data), 64'd2047);

        // Re-arm from DONE
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("rearm_done",  64'(bus.done), 64'd0);
        chk("rearm_busy",  64'(bus.busy), 64'd1);
        chk("rearm_sat",   64'(bus.sat_flag), 64'd0);
        chk("rearm_count", 64'(bus.sample_count), 64'd0);

        // Rounding and saturation
        dv[0] = sh(5);                    ev[0] = 16'd5;
        dv[1] = sh(5) + half;             ev[1] = 16'd6;
        dv[2] = -sh(3);                   ev[2] = 16'hFFFD;
        dv[3] = -sh(3) - half;            ev[3] = 16'hFFFD;
        dv[4] = sh(32767) + half - 93'sd1; ev[4] = 16'h7FFF;
        dv[5] = -sh(32768);               ev[5] = 16'h8000;
        dv[6] = sh(40000);                ev[6] = 16'h7FFF;
        dv[7] = -sh(40000);               ev[7] = 16'h8000;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = dv[i];
            tick();
        end
        bus.valid_in = 1'b0;
        tick();
        chk("nosat_flag",  64'(bus.sat_flag), 64'd0);
        chk("nosat_count", 64'(bus.sample_count), 64'd6);
        push(dv[6]);
        chk("sat_flag_set", 64'(bus.sat_flag), 64'd1);
        push(dv[7]);
        tick();
        chk("sat_count", 64'(bus.sample_count), 64'd8);
        for (int i = 0; i < 8; i++) rd(i, ev[i], $sformatf("round_rd%0d", i));
        chk("sat_flag_hold", 64'(bus.sat_flag), 64'd1);

        // Read of the address being written returns the old contents
        push(sh(77));
        bus.rd_en   = 1'b1;
        bus.rd_addr = 11'd8;
        tick();
        bus.rd_en   = 1'b0;
        chk("rdw_old",   64'(bus.rd_data), 64'd8);
        chk("rdw_count", 64'(bus.sample_count), 64'd9);
        rd(8, 16'd77, "rdw_new");

        // Reset mid-frame after 100 writes
        bus.valid_in = 1'b1;
        for (int i = 0; i < 91; i++) begin
            bus.data_in = sh(i);
            tick();
        end
        bus.valid_in = 1'b0;
        tick();
        chk("pre_rst_count", 64'(bus.sample_count), 64'd100);
        rst = 1'b0;
        tick();
        chk("mrst_rd_data",  64'(bus.rd_data), 64'd0);
        chk("mrst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("mrst_busy",     64'(bus.busy), 64'd0);
        chk("mrst_done",     64'(bus.done), 64'd0);
        chk("mrst_count",    64'(bus.sample_count), 64'd0);
        chk("mrst_sat",      64'(bus.sat_flag), 64'd0);
        rst = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        push(sh(7));
        tick();
        chk("post_rst_count", 64'(bus.sample_count), 64'd1);
        rd(0, 16'd7, "post_rst_rd0");

        // Overrun: only up to FRAME_LEN accepts are stored
        bus.valid_in = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            bus.data_in = sh(i);
            tick();
        end
        bus.valid_in = 1'b0;
        tick();
        chk("ovr_done",  64'(bus.done), 64'd1);
        chk("ovr_busy",  64'(bus.busy), 64'd0);
        chk("ovr_count", 64'(bus.sample_count), 64'd2048);
        rd(0,    16'd7,    "ovr_rd0");
        rd(1,    16'd0,    "ovr_rd1");
        rd(2047, 16'd2046, "ovr_rd2047");

        // Valids in DONE are dropped
        for (int i = 0; i < 5; i++) push(sh(9));
        tick();
        chk("done_drop_count", 64'(bus.sample_count), 64'd2048);
        chk("done_drop_done",  64'(bus.done), 64'd1);
        rd(0, 16'd7, "done_drop_rd0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
